ram_bridge: RTL

- Responder for the core's data-memory port (ram_en / ram_write_en / ram_addr / ram_write_data / ram_read_data).
- Converts single-cycle core accesses into a req/ack transaction on a slower backing-memory bus.
- Holds the pipeline with the core's stall input until each transaction completes.
- Has a timeout path, so a dead backing bus cannot hang the core.

---
 rtl/ram_bridge_pkg.sv | 19 +
 rtl/ram_bridge_bus_timer.sv | 36 +++
 rtl/ram_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ram_bridge_pkg.sv
// rtl/ram_bridge_pkg.sv - shared widths, bridge state encodings and defaults for ram_bridge
package ram_bridge_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [DATA_BUS-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Backing bus is word addressed; the two byte-offset bits are always cleared.
    localparam logic [ADDR_BUS-1:0] WORD_MASK = {{(ADDR_BUS-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        BRG_IDLE = 2'd0,
        BRG_REQ  = 2'd1,
        BRG_DONE = 2'd2
    } brg_state_e;

endpackage

// File: rtl/ram_bridge_bus_timer.sv
// rtl/ram_bridge_bus_timer.sv - request timeout counter with terminal count at TIMEOUT-1
module ram_bridge_bus_timer #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/ram_bridge.sv
// rtl/ram_bridge.sv - core data-memory port to req/ack backing bus bridge with timeout
module ram_bridge
    import ram_bridge_pkg::*;
#(
    parameter int unsigned          TIMEOUT  = 256,
    parameter int unsigned          CNT_W    = 8,
    parameter logic [DATA_BUS-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ram_en,
    input  logic [MEM_SEL_BUS-1:0] ram_write_en,
    input  logic [ADDR_BUS-1:0]    ram_addr,
    input  logic [DATA_BUS-1:0]    ram_write_data,
    output logic [DATA_BUS-1:0]    ram_read_data,
    output logic                   stall,
    output logic                   mem_req,
    output logic [MEM_SEL_BUS-1:0] mem_we,
    output logic [ADDR_BUS-1:0]    mem_addr,
    output logic [DATA_BUS-1:0]    mem_wdata,
    input  logic [DATA_BUS-1:0]    mem_rdata,
    input  logic                   mem_ack,
    output logic                   bus_err
);

    brg_state_e             state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [MEM_SEL_BUS-1:0] mem_we_q, mem_we_d;
    logic [ADDR_BUS-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_BUS-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_BUS-1:0]    rdata_q, rdata_d;
    logic                   bus_err_q, bus_err_d;
    logic                   stall_c;
    logic                   timer_clr;
    logic                   timer_en;
    logic                   timer_tc;
    logic                   is_read;

    ram_bridge_bus_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_bus_timer (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (timer_clr),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    assign is_read = (mem_we_q == '0);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        stall_c     = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            BRG_IDLE: begin
                stall_c = ram_en;
                if (ram_en) begin
                    mem_addr_d  = ram_addr & WORD_MASK;
                    mem_we_d    = ram_write_en;
                    mem_wdata_d = ram_write_data;
                    mem_req_d   = 1'b1;
                    timer_clr   = 1'b1;
                    state_d     = BRG_REQ;
                end
            end
            BRG_REQ: begin
                stall_c  = 1'b1;
                timer_en = 1'b1;
                // An ack arriving on the terminal-count cycle is a real completion.
                if (mem_ack) begin
                    if (is_read) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = BRG_DONE;
                end else if (timer_tc) begin
                    if (is_read) begin
                        rdata_d = ERR_DATA;
                    end
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = BRG_DONE;
                end
            end
            BRG_DONE: begin
                // ram_en here is still the completed access; it must not re-issue.
                state_d = BRG_IDLE;
            end
            default: begin
                state_d = BRG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BRG_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall         = rst & stall_c;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign ram_read_data = rdata_q;
    assign bus_err       = bus_err_q;

endmodule
